// File: rtl/trng_entropy_collector.sv
// Entropy collector: packs the sample LSB into words, drops words tainted by the
// health test, buffers clean words in a small FWFT FIFO and handles total-failure alarms.
module trng_entropy_collector #(
  parameter int NBITS         = 8,
  parameter int WORD_W        = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARTUP_WORDS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NBITS-1:0]              samples,
  input  logic                          ht_error,
  input  logic                          ht_total_failure,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [WORD_W-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          alarm,
  input  logic                          alarm_clr,
  output logic [15:0]                   drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORD_W);
  localparam int SW = $clog2(STARTUP_WORDS + 1) + 1;

  typedef enum logic [1:0] {ST_STARTUP, ST_COLLECT, ST_ALARM} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WORD_W-2:0]   r_sreg;
  logic [CW-1:0]       r_bit_cnt;
  logic                r_taint;
  logic [SW-1:0]       r_startup_cnt;
  logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_level;
  logic [15:0]         r_drop_cnt;

  logic                w_capture;
  logic                w_word_done;
  logic [WORD_W-1:0]   w_word;
  logic                w_tainted;
  logic                w_clean_done;
  logic                w_startup_last;
  logic                w_full;
  logic                w_rd_valid;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_unused_samples;

  assign w_unused_samples = ^samples;

  assign w_capture      = (r_state != ST_ALARM);
  assign w_word_done    = w_capture && (r_bit_cnt == CW'(WORD_W - 1));
  assign w_word         = {r_sreg, samples[0]};
  assign w_tainted      = r_taint | ht_error;
  assign w_clean_done   = w_word_done && !w_tainted && !ht_total_failure;
  assign w_startup_last = (r_state == ST_STARTUP) && w_clean_done &&
                          ((r_startup_cnt + 1'b1) == SW'(STARTUP_WORDS));
  assign w_full         = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_rd_valid     = (r_level != '0) && (r_state != ST_ALARM);
  // A total failure freezes the FIFO for that edge so the flush wins cleanly.
  assign w_pop          = w_rd_valid && rd_ready && !ht_total_failure;
  assign w_push         = w_clean_done && (r_state == ST_COLLECT) && (!w_full || w_pop);
  assign w_drop         = w_word_done && !ht_total_failure &&
                          (w_tainted || ((r_state == ST_COLLECT) && !w_push));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_STARTUP;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (ht_total_failure) begin
      w_state_next = ST_ALARM;
    end else begin
      case (r_state)
        ST_STARTUP: if (w_startup_last) w_state_next = ST_COLLECT;
        ST_ALARM:   if (alarm_clr)      w_state_next = ST_STARTUP;
        default:    w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ht_total_failure) begin
      r_sreg        <= '0;
      r_bit_cnt     <= '0;
      r_taint       <= 1'b0;
      r_startup_cnt <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
    end else begin
      if (w_capture) begin
        r_sreg    <= w_word[WORD_W-2:0];
        r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + 1'b1;
        r_taint   <= w_word_done ? 1'b0 : w_tainted;
      end
      if ((r_state == ST_STARTUP) && w_clean_done) r_startup_cnt <= r_startup_cnt + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= w_word;
  end

  // Drop count survives alarms; only a full reset clears it.
  always_ff @(posedge clk) begin
    if (rst)                                  r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign rd_valid   = w_rd_valid;
  assign rd_data    = w_rd_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_level = r_level;
  assign alarm      = (r_state == ST_ALARM);
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_trng_entropy_collector.sv
// Bench for trng_entropy_collector: directed latency/alarm/reset scenarios plus random
// traffic, checked against a word-level model and a scoreboard of expected FIFO words.
module tb_trng_entropy_collector;

  localparam int NBITS         = 8;
  localparam int WORD_W        = 32;
  localparam int FIFO_DEPTH    = 4;
  localparam int STARTUP_WORDS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic [NBITS-1:0]    samples = '0;
  logic                ht_error = 1'b0;
  logic                ht_total_failure = 1'b0;
  logic                rd_valid;
  logic                rd_ready = 1'b0;
  logic [WORD_W-1:0]   rd_data;
  logic [2:0]          fifo_level;
  logic                alarm;
  logic                alarm_clr = 1'b0;
  logic [15:0]         drop_cnt;

  trng_entropy_collector #(
    .NBITS(NBITS), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .STARTUP_WORDS(STARTUP_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .samples(samples), .ht_error(ht_error),
    .ht_total_failure(ht_total_failure), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .fifo_level(fifo_level), .alarm(alarm), .alarm_clr(alarm_clr),
    .drop_cnt(drop_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = startup, 1 = collect, 2 = alarm.
  int                m_state;
  logic [WORD_W-1:0] m_word;
  int                m_nbits;
  bit                m_taint;
  int                m_scnt;
  int                m_level;
  int                m_drop;
  logic [WORD_W-1:0] exp_q[$];

  function void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function void model_step(input bit s0, input bit e, input bit f, input bit c,
                           input bit r, input bit rs);
    bit pop;
    if (rs) begin
      m_state = 0; m_word = '0; m_nbits = 0; m_taint = 0; m_scnt = 0;
      m_level = 0; m_drop = 0; exp_q.delete();
    end else if (f) begin
      m_state = 2; m_word = '0; m_nbits = 0; m_taint = 0; m_scnt = 0;
      m_level = 0; exp_q.delete();
    end else if (m_state == 2) begin
      if (c) m_state = 0;
    end else begin
      pop = (m_level > 0) && r;
      m_word = (m_word << 1) | WORD_W'(s0);
      m_nbits++;
      m_taint = m_taint | e;
      if (m_nbits == WORD_W) begin
        if (m_taint) begin
          if (m_drop < 65535) m_drop++;
        end else if (m_state == 0) begin
          m_scnt++;
          if (m_scnt == STARTUP_WORDS) m_state = 1;
        end else if (m_level < FIFO_DEPTH || pop) begin
          exp_q.push_back(m_word);
          m_level++;
        end else begin
          if (m_drop < 65535) m_drop++;
        end
        m_nbits = 0; m_taint = 0; m_word = '0;
      end
      if (pop) m_level--;
    end
  endfunction

  task automatic check_obs();
    chk("rd_valid", rd_valid, (m_level > 0) && (m_state != 2));
    chk("fifo_level", fifo_level, m_level);
    chk("alarm", alarm, m_state == 2);
    chk("drop_cnt", drop_cnt, m_drop);
    if (!rd_valid) chk("rd_data_idle", rd_data, 0);
  endtask

  task automatic step(input bit s0, input bit e, input bit f, input bit c,
                      input bit r, input bit rs);
    logic [NBITS-1:0] s;
    s = NBITS'($urandom);
    s[0] = s0;
    samples = s; ht_error = e; ht_total_failure = f; alarm_clr = c;
    rd_ready = r; rst = rs;
    model_step(s0, e, f, c, r, rs);
    @(posedge clk);
    #1;
    check_obs();
  endtask

  // Scoreboard monitor: a pop happens on the next edge, so compare the head now.
  always @(negedge clk) begin
    if (rd_valid && rd_ready && !rst && !ht_total_failure) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data: got %h but no word was expected", rd_data);
      end else begin
        chk("pop_data", rd_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_valid", rd_valid, 0);
    chk("reset_level", fifo_level, 0);

    // Alternating bits, consumer idle: latency, fill and overflow.
    for (int e = 1; e <= 224; e++) begin
      step(bit'(e % 2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (e == 95)  chk("A_valid_e95", rd_valid, 0);
      if (e == 96)  chk("A_valid_e96", rd_valid, 1);
      if (e == 96)  chk("A_data_e96", rd_data, 32'hAAAAAAAA);
      if (e == 192) chk("A_level_e192", fifo_level, 4);
      if (e == 223) chk("A_drop_e223", drop_cnt, 0);
      if (e == 224) chk("A_drop_e224", drop_cnt, 1);
    end
    repeat (8) step(bit'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Health-test error at bit 10 of the first collect word.
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 128; e++) begin
      step(bit'($urandom), bit'(e == 75), 1'b0, 1'b0, 1'b0, 1'b0);
      if (e == 96)  chk("B_drop_e96", drop_cnt, 1);
      if (e == 96)  chk("B_valid_e96", rd_valid, 0);
      if (e == 127) chk("B_valid_e127", rd_valid, 0);
      if (e == 128) chk("B_valid_e128", rd_valid, 1);
    end
    repeat (4) step(bit'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Full FIFO with a pop on the completing edge, then an overflow drop.
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 256; e++) begin
      step(bit'($urandom), 1'b0, 1'b0, 1'b0, bit'(e == 224), 1'b0);
      if (e == 224) chk("C_level_e224", fifo_level, 4);
      if (e == 224) chk("C_drop_e224", drop_cnt, 0);
      if (e == 256) chk("C_drop_e256", drop_cnt, 1);
    end
    step(bit'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("D_level_pre", fifo_level, 3);

    // Total failure flushes; clear is ignored while the failure persists.
    step(bit'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("D_alarm", alarm, 1);
    chk("D_level_flush", fifo_level, 0);
    chk("D_drop_kept", drop_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      step(bit'($urandom), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("D_alarm_held", alarm, 1);
      chk("D_valid_held", rd_valid, 0);
    end
    step(bit'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("D_alarm_cleared", alarm, 0);
    for (int e = 1; e <= 145; e++) begin
      step(bit'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (e == 95) chk("D_valid_e95", rd_valid, 0);
      if (e == 96) chk("D_valid_e96", rd_valid, 1);
    end
    chk("E_level_pre", fifo_level, 2);

    // Reset mid-word with two words buffered.
    step(bit'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("E_rst_valid", rd_valid, 0);
    chk("E_rst_data", rd_data, 0);
    chk("E_rst_level", fifo_level, 0);
    chk("E_rst_alarm", alarm, 0);
    chk("E_rst_drop", drop_cnt, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step(bit'($urandom),
           bit'($urandom_range(0, 79) == 0),
           bit'($urandom_range(0, 399) == 0),
           bit'($urandom_range(0, 3) == 0),
           bit'($urandom),
           bit'($urandom_range(0, 599) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
